fetch_unit: RTL

//   Instruction-fetch stage between the program counter and decode.
//   - Takes the current PC, issues instruction-memory requests over a valid/ready handshake.
//   - Buffers returned instructions with their PCs in a small queue.
//   - Drives the next PC back into the program counter; handles branch/jump redirects.
//   - The program counter loads every cycle, so this block holds the PC on stall by returning pc_i.

---
 rtl/fetch_pkg.sv | 24 ++
 rtl/fetch_if.sv | 33 +++
 rtl/fetch_fifo.sv | 64 ++++++
 rtl/fetch_unit.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fetch_pkg
// Brief   : Shared constants, FSM state type and sizing helper for the fetch stage.
// Revision: 1.0
// ============================================================================
package fetch_pkg;

  localparam int          INSTR_BYTES = 4;
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  // Counter width able to hold the value DEPTH itself.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_if.sv
`default_nettype none
// ============================================================================
// Module  : fetch_if
// Brief   : Instruction-memory request/response and decode-side handshake bundle.
// Revision: 1.0
// ============================================================================
interface fetch_if #(
  parameter int PC_W    = 64,
  parameter int INSTR_W = 32
);

  logic               imem_req_valid;
  logic               imem_req_ready;
  logic [PC_W-1:0]    imem_req_addr;
  logic               imem_rsp_valid;
  logic [INSTR_W-1:0] imem_rsp_data;
  logic               inst_valid;
  logic               inst_ready;
  logic [INSTR_W-1:0] inst;
  logic [PC_W-1:0]    inst_pc;

  modport master (
    output imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready
  );

endinterface
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module  : fetch_fifo
// Brief   : Synchronous FIFO with flush; push and pop may coincide at any occupancy.
// Revision: 1.0
// ============================================================================
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  wire                   clk,
  input  wire                   rst,
  input  wire                   i_push,
  input  wire                   i_pop,
  input  wire                   i_flush,
  input  wire [WIDTH-1:0]       i_data,
  output logic [WIDTH-1:0]      o_data,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                  o_empty,
  output logic                  o_full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd_ptr];

  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  assign w_pop  = i_pop & ~o_empty;
  assign w_push = i_push & (~o_full | w_pop);

  always_ff @(posedge clk) begin
    if (w_push && !i_flush) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module  : fetch_unit
// Brief   : Fetch stage: issues PC requests, queues returned instructions, drives next PC.
// Revision: 1.0
// ============================================================================
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              PC_W     = 64,
  parameter int              INSTR_W  = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 2
) (
  input  wire              clk_i,
  input  wire              rst_i,
  input  wire [PC_W-1:0]   pc_i,
  output logic [PC_W-1:0]  pc_next_o,
  input  wire              redirect_i,
  input  wire [PC_W-1:0]   redirect_pc_i,
  fetch_if.master          bus
);

  localparam int CW = cnt_width(DEPTH);
  localparam int QW = PC_W + INSTR_W;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_outstanding;
  logic [CW-1:0]   w_outstanding_nxt;
  logic [CW-1:0]   r_stale;
  logic [CW-1:0]   w_stale_nxt;
  logic [CW-1:0]   w_pend;
  logic [CW:0]     w_occupancy;
  logic            w_credit;
  logic            w_req_valid;
  logic            w_req_fire;
  logic            w_rsp_drop;
  logic            w_rsp_take;
  logic            w_inst_pop;
  logic [PC_W-1:0] w_infl_pc;
  logic [CW-1:0]   w_infl_count;
  logic            w_infl_empty;
  logic            w_infl_full;
  logic [QW-1:0]   w_q_data;
  logic [CW-1:0]   w_q_count;
  logic            w_q_empty;
  logic            w_q_full;
  logic            w_unused;

  assign w_occupancy = {1'b0, r_outstanding} + {1'b0, w_q_count};
  assign w_credit    = w_occupancy < (CW+1)'(DEPTH);
  assign w_req_valid = ~rst_i & (r_state == ST_RUN) & w_credit & ~redirect_i;
  assign w_req_fire  = w_req_valid & bus.imem_req_ready;
  assign w_rsp_drop  = bus.imem_rsp_valid & (r_stale != '0);
  // A response with nothing owed is a protocol error and is ignored.
  assign w_rsp_take  = bus.imem_rsp_valid & (r_stale == '0) & (r_outstanding != '0);
  assign w_inst_pop  = ~w_q_empty & bus.inst_ready & ~redirect_i;
  assign w_pend      = r_outstanding + r_stale;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state       <= ST_IDLE;
      r_outstanding <= '0;
      r_stale       <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_outstanding <= w_outstanding_nxt;
      r_stale       <= w_stale_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_outstanding_nxt = r_outstanding;
    w_stale_nxt       = r_stale;
    if (redirect_i) begin
      // Every response still owed becomes stale; one arriving now is dropped here.
      w_stale_nxt       = (bus.imem_rsp_valid && (w_pend != '0)) ? w_pend - CW'(1) : w_pend;
      w_outstanding_nxt = '0;
      w_state_nxt       = (w_stale_nxt != '0) ? ST_FLUSH : ST_RUN;
    end else begin
      w_outstanding_nxt = r_outstanding + CW'(w_req_fire) - CW'(w_rsp_take);
      if (w_rsp_drop) begin
        w_stale_nxt = r_stale - CW'(1);
      end
      case (r_state)
        ST_IDLE:  w_state_nxt = ST_RUN;
        ST_RUN:   w_state_nxt = ST_RUN;
        ST_FLUSH: if (w_stale_nxt == '0) w_state_nxt = ST_RUN;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    pc_next_o = pc_i;
    if (rst_i) begin
      pc_next_o = RESET_PC;
    end else if (redirect_i) begin
      pc_next_o = redirect_pc_i;
    end else if (w_req_fire) begin
      pc_next_o = pc_i + PC_W'(INSTR_BYTES);
    end
  end

  fetch_fifo #(
    .WIDTH (PC_W),
    .DEPTH (DEPTH)
  ) u_inflight_q (
    .clk     (clk_i),
    .rst     (rst_i),
    .i_push  (w_req_fire),
    .i_pop   (w_rsp_take),
    .i_flush (redirect_i),
    .i_data  (pc_i),
    .o_data  (w_infl_pc),
    .o_count (w_infl_count),
    .o_empty (w_infl_empty),
    .o_full  (w_infl_full)
  );

  fetch_fifo #(
    .WIDTH (QW),
    .DEPTH (DEPTH)
  ) u_instr_q (
    .clk     (clk_i),
    .rst     (rst_i),
    .i_push  (w_rsp_take & ~redirect_i),
    .i_pop   (w_inst_pop),
    .i_flush (redirect_i),
    .i_data  ({w_infl_pc, bus.imem_rsp_data}),
    .o_data  (w_q_data),
    .o_count (w_q_count),
    .o_empty (w_q_empty),
    .o_full  (w_q_full)
  );

  assign w_unused = &{1'b0, w_infl_count, w_infl_empty, w_infl_full, w_q_full};

  assign bus.imem_req_valid = w_req_valid;
  assign bus.imem_req_addr  = rst_i ? '0 : pc_i;
  assign bus.inst_valid     = ~rst_i & ~w_q_empty;
  assign bus.inst_pc        = rst_i ? '0 : w_q_data[INSTR_W +: PC_W];
  assign bus.inst           = rst_i     ? '0 :
                              w_q_empty ? INSTR_W'(NOP_INSTR) : w_q_data[INSTR_W-1:0];

endmodule
`default_nettype wire
